// File: rtl/lnet_cfg_pkg.sv
// Shared types and sizing helpers for the runtime-programmable LogicNets neuron.
package lnet_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } cfg_state_e;

    // Number of configuration words needed to cover the whole truth table.
    function automatic int cfg_words(input int in_bits, input int out_bits, input int cfg_w);
        return ((1 << in_bits) * out_bits) / cfg_w;
    endfunction

    // Table entries carried by one configuration word.
    function automatic int ent_per_word(input int out_bits, input int cfg_w);
        return cfg_w / out_bits;
    endfunction

    // Word counter width; one spare code so an optional trailing word fits.
    function automatic int cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/lnet_lut_ram.sv
// Truth-table storage: one CFG_W-wide row per configuration word, so a single
// write updates ENT_PER_WORD entries. Asynchronous read selects one entry;
// the parent registers it. Contents are deliberately not reset.
// Assumes at least two configuration words and two entries per word.
module lnet_lut_ram
    import lnet_cfg_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2,
    parameter int CFG_W    = 32,
    localparam int WORDS   = cfg_words(IN_BITS, OUT_BITS, CFG_W),
    localparam int EPW     = ent_per_word(OUT_BITS, CFG_W),
    localparam int EPW_LG  = $clog2(EPW),
    localparam int WA_W    = $clog2(WORDS)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [WA_W-1:0]     waddr_i,
    input  logic [CFG_W-1:0]    wdata_i,
    input  logic [IN_BITS-1:0]  raddr_i,
    output logic [OUT_BITS-1:0] rdata_o
);

    logic [CFG_W-1:0]  mem_q [WORDS];
    logic [CFG_W-1:0]  rword;
    logic [EPW_LG-1:0] rsel;

    // Whole-row write: entry j of the word lands at bits [OUT_BITS*j +: OUT_BITS].
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Upper address bits pick the row, lower bits pick the entry within it.
    assign rword   = mem_q[raddr_i[IN_BITS-1 -: WA_W]];
    assign rsel    = raddr_i[EPW_LG-1:0];
    assign rdata_o = rword[int'(rsel) * OUT_BITS +: OUT_BITS];

endmodule

// File: rtl/lnet_lut_cfg_ctrl.sv
// Runtime-programmable LogicNets neuron: loads its truth table from a
// configuration stream, then serves 1-cycle lookups with a valid/ready output
// register. Reconfiguration from RUN first drains any pending result.
// Optional build macro LNET_CFG_CHECKSUM_EN: the load carries one extra word
// that must equal the XOR of the table words; a mismatch sets sticky cfg_err.
module lnet_lut_cfg_ctrl
    import lnet_cfg_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2,
    parameter int CFG_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                lut_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int CFG_WORDS = cfg_words(IN_BITS, OUT_BITS, CFG_W);
    localparam int WA_W      = $clog2(CFG_WORDS);
    localparam int CNT_W     = cnt_width(CFG_WORDS);
    localparam logic [CNT_W-1:0] TBL_WORDS = CNT_W'(CFG_WORDS);
`ifdef LNET_CFG_CHECKSUM_EN
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CFG_WORDS);
`else
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CFG_WORDS - 1);
`endif

    cfg_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ov_q, ov_d;
    logic [OUT_BITS-1:0] od_q, od_d;
    logic                done_q, done_d;
`ifdef LNET_CFG_CHECKSUM_EN
    logic                err_q, err_d;
    logic [CFG_W-1:0]    csum_q, csum_d;
`endif

    logic                cfg_hs;
    logic                in_hs;
    logic                ram_we;
    logic [OUT_BITS-1:0] rd_data;

    // A word arriving together with cfg_start is dropped: the restart wins.
    assign cfg_ready = (state_q == ST_LOAD);
    assign lut_ready = (state_q == ST_RUN);
    assign in_ready  = lut_ready & (~ov_q | out_ready);
    assign cfg_hs    = cfg_valid & cfg_ready & ~cfg_start;
    assign in_hs     = in_valid & in_ready;
    assign ram_we    = cfg_hs & (cnt_q < TBL_WORDS);

    assign cfg_done  = done_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
`ifdef LNET_CFG_CHECKSUM_EN
    assign cfg_err   = err_q;
`else
    assign cfg_err   = 1'b0;
`endif

    lnet_lut_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .CFG_W    (CFG_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (cnt_q[WA_W-1:0]),
        .wdata_i (cfg_data),
        .raddr_i (in_data),
        .rdata_o (rd_data)
    );

    // Next-state: load sequencing, drain-before-reload, output register hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        od_d    = od_q;
        done_d  = 1'b0;
`ifdef LNET_CFG_CHECKSUM_EN
        err_d   = err_q;
        csum_d  = csum_q;
`endif

        // Output register: capture on accept, clear on consume, else hold.
        if (in_hs) begin
            ov_d = 1'b1;
            od_d = rd_data;
        end else if (out_ready) begin
            ov_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
`ifdef LNET_CFG_CHECKSUM_EN
                    err_d   = 1'b0;
                    csum_d  = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    cnt_d = '0;
`ifdef LNET_CFG_CHECKSUM_EN
                    err_d  = 1'b0;
                    csum_d = '0;
`endif
                end else if (cfg_hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef LNET_CFG_CHECKSUM_EN
                    csum_d = csum_q ^ cfg_data;
                    if (cnt_q == LAST_IDX) begin
                        if (cfg_data == csum_q) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
`else
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (cfg_start) begin
                    state_d = ST_DRAIN;
`ifdef LNET_CFG_CHECKSUM_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_DRAIN: begin
                if (!ov_q || out_ready) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
`ifdef LNET_CFG_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            done_q  <= 1'b0;
`ifdef LNET_CFG_CHECKSUM_EN
            err_q   <= 1'b0;
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            done_q  <= done_d;
`ifdef LNET_CFG_CHECKSUM_EN
            err_q   <= err_d;
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: doc/lnet_lut_cfg_ctrl.md
Name: lnet_lut_cfg_ctrl

Overview:
- Runtime-programmable LogicNets neuron. It holds a 2^IN_BITS x OUT_BITS truth table in distributed RAM and serves lookups in place of a hard-coded case-ROM neuron.
- Sequences table loading from a 32-bit configuration stream.
- Blocks lookups while the table is invalid or being rewritten.
- Drains in-flight results before any reconfiguration.
- Sits between the layer input register and the next layer, one instance per reconfigurable neuron.

Parameters:
- IN_BITS, 6, neuron input width (fan-in x input bitwidth); table depth = 2^IN_BITS.
- OUT_BITS, 2, neuron output width.
- CFG_W, 32, configuration word width. Requires (2^IN_BITS * OUT_BITS) % CFG_W == 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_start  in  1  request (re)load of the table.
- cfg_valid  in  1  configuration word valid.
- cfg_ready  out  1  configuration word accepted when cfg_valid & cfg_ready.
- cfg_data  in  CFG_W  configuration word.
- cfg_done  out  1  one-cycle pulse when the load completes successfully.
- cfg_err  out  1  sticky load error (checksum build only).
- lut_ready  out  1  table valid, lookups enabled.
- in_valid  in  1  lookup request.
- in_ready  out  1  lookup accepted when in_valid & in_ready.
- in_data  in  IN_BITS  lookup address (concatenated neuron inputs).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_BITS  looked-up neuron output.

Behaviour:
- Constants: CFG_WORDS = 2^IN_BITS*OUT_BITS/CFG_W (4 at defaults); ENT_PER_WORD = CFG_W/OUT_BITS (16).
- Packing: word k, bits [OUT_BITS*j +: OUT_BITS] -> entry k*ENT_PER_WORD + j. Word 0 is sent first.
- States: IDLE, LOAD, RUN, DRAIN.
- Reset (any state, including mid-load):
  - State IDLE, word counter 0.
  - cfg_ready, cfg_done, cfg_err, lut_ready, in_ready, out_valid all 0; out_data 0.
  - Table contents are not reset.
- IDLE:
  - lut_ready=0, in_ready=0.
  - cfg_start -> LOAD (counter=0) next cycle.
- LOAD:
  - cfg_ready=1; each handshake writes ENT_PER_WORD entries and increments the counter.
  - The handshake on the last word -> RUN, with cfg_done=1 and lut_ready=1 in the following cycle.
  - cfg_start during LOAD restarts: counter=0, and that cycle's word is discarded.
- RUN:
  - lut_ready=1.
  - in_ready = !out_valid | out_ready. This depends only on the state and the output register, never on cfg_start.
  - Lookup latency is 1 cycle: a handshake at cycle t gives out_valid=1 and out_data=table[in_data] at t+1.
  - out_data/out_valid hold while out_valid & !out_ready.
  - Full throughput with out_ready=1.
  - cfg_start -> DRAIN. A lookup accepted in the same cycle as cfg_start completes normally.
- DRAIN:
  - lut_ready=0, in_ready=0, cfg_ready=0.
  - Once out_valid=0 (or is being consumed this cycle) -> LOAD.
- cfg_start in DRAIN is ignored (already pending).
- cfg_valid outside LOAD is ignored.
- cfg_err clears only on rst or on a cfg_start that is accepted.

Optional Feature:
- Macro: LNET_CFG_CHECKSUM_EN.
- With the macro defined:
  - LOAD expects CFG_WORDS+1 words; the last word must equal the XOR of the preceding CFG_WORDS words.
  - Table writes go to the RAM as received.
  - Match -> RUN and cfg_done.
  - Mismatch -> IDLE, cfg_err=1, lut_ready=0, no cfg_done.
- Without the macro: exactly CFG_WORDS words are expected, and cfg_err is tied 0.

Decomposition:
- Package lnet_cfg_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DRAIN);
  - the CFG_WORDS and ENT_PER_WORD calculations as functions of the parameters;
  - the counter width helper ($clog2(CFG_WORDS+1)).
- Sub-module lnet_lut_ram:
  - 2^IN_BITS x OUT_BITS distributed RAM;
  - write port is ENT_PER_WORD entries wide, synchronous;
  - read is asynchronous, registered in the parent.

Test Plan:
- Reset values: assert rst for 2 cycles -> every output 0. in_valid=1 in IDLE -> in_ready stays 0, no out_valid.
- Uniform table: cfg_start, then 4 words 0x5555_5555 -> cfg_done pulse 1 cycle after the 4th handshake. Lookup in_data=6'h2A -> out_data=2'b01 one cycle later.
- Word packing: word0=0x0000_000C, words1-3=0 -> lookup 0 gives 2'b00 and lookup 1 gives 2'b11. Word3=0xC000_0000 -> lookup 6'h3F gives 2'b11.
- Backpressure: stream lookups 0..7 with out_ready low for 3 cycles -> in_ready=0, out_data held. After release, all 8 results arrive in order with none lost or duplicated.
- Reconfig while a result is pending:
  - cfg_start with out_valid=1 and out_ready=0 -> DRAIN, cfg_ready=0.
  - Raise out_ready -> LOAD the next cycle.
  - Load 0xFFFF_FFFF x4 -> lookup gives 2'b11.
- Reset mid-load, then checksum (LNET_CFG_CHECKSUM_EN):
  - rst after 2 words -> IDLE, lut_ready=0.
  - Full load with a bad XOR word -> cfg_err=1, no cfg_done.
  - Correct XOR word -> cfg_done and cfg_err cleared.
